// File: rtl/riot_pkg.sv
// rtl/riot_pkg.sv - register map, interval encoding and prescaler helpers for the RIOT timer/I-O
package riot_pkg;

   localparam int PRESCALE_W = 10;

   // Port B pin value presented while no console switches are wired
   localparam logic [7:0] PB_RESET_IN = 8'hFF;

   localparam logic [4:0] ADDR_SWCHA    = 5'h00;
   localparam logic [4:0] ADDR_SWACNT   = 5'h01;
   localparam logic [4:0] ADDR_SWCHB    = 5'h02;
   localparam logic [4:0] ADDR_SWBCNT   = 5'h03;
   localparam logic [4:0] ADDR_INTIM    = 5'h04;
   localparam logic [4:0] ADDR_TIMINT   = 5'h05;
   localparam logic [4:0] ADDR_TIM1T    = 5'h14;
   localparam logic [4:0] ADDR_TIM8T    = 5'h15;
   localparam logic [4:0] ADDR_TIM64T   = 5'h16;
   localparam logic [4:0] ADDR_TIM1024T = 5'h17;

   typedef enum logic [1:0] {
      IV_1    = 2'b00,
      IV_8    = 2'b01,
      IV_64   = 2'b10,
      IV_1024 = 2'b11
   } interval_e;

   // Prescaler reload value: ticks per count minus one
   function automatic logic [PRESCALE_W-1:0] interval_m1(input interval_e sel);
      case (sel)
         IV_1:    return 10'd0;
         IV_8:    return 10'd7;
         IV_64:   return 10'd63;
         default: return 10'd1023;
      endcase
   endfunction

endpackage

// File: rtl/riot_timer_io_if.sv
// rtl/riot_timer_io_if.sv - 6502-side bus between the CPU core and the RIOT timer/I-O
interface riot_timer_io_if;
   logic       cpu_tick;
   logic       cs;
   logic [4:0] addr;
   logic       we;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       irq;

   modport master (output cpu_tick, cs, addr, we, wdata, input rdata, irq);
   modport slave  (input cpu_tick, cs, addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/riot_interval_timer.sv
// rtl/riot_interval_timer.sv - 8-bit interval timer with 1/8/64/1024 prescaler and underflow flag
module riot_interval_timer
   import riot_pkg::*;
#(
   parameter logic [7:0] TIMER_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [7:0] ld_val,
   input  interval_e  ld_sel,
   input  logic       clr_flag,
   output logic [7:0] count,
   output logic       flag
);

   logic [7:0]            counter_q, counter_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] ivl_m1_q, ivl_m1_d;
   logic                  flag_q, flag_d;
   logic                  underflow;

   always_comb begin
      counter_d  = counter_q;
      prescale_d = prescale_q;
      ivl_m1_d   = ivl_m1_q;
      flag_d     = flag_q;
      underflow  = 1'b0;
      if (tick) begin
         if (load) begin
            counter_d  = ld_val;
            ivl_m1_d   = interval_m1(ld_sel);
            prescale_d = '0;
            flag_d     = 1'b0;
         end else begin
            if (clr_flag) flag_d = 1'b0;
            if (prescale_q != '0) begin
               prescale_d = prescale_q - PRESCALE_W'(1);
            end else begin
               counter_d = counter_q - 8'd1;
               underflow = (counter_q == 8'h00);
               // After underflow the counter free-runs at one count per tick until reloaded
               if (underflow) begin
                  flag_d   = 1'b1;
                  ivl_m1_d = '0;
               end
               prescale_d = (flag_q | underflow) ? '0 : ivl_m1_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter_q  <= TIMER_RESET;
         prescale_q <= '0;
         ivl_m1_q   <= interval_m1(IV_1024);
         flag_q     <= 1'b0;
      end else begin
         counter_q  <= counter_d;
         prescale_q <= prescale_d;
         ivl_m1_q   <= ivl_m1_d;
         flag_q     <= flag_d;
      end
   end

   assign count = counter_q;
   assign flag  = flag_q;

endmodule

// File: rtl/riot_timer_io.sv
// rtl/riot_timer_io.sv - 6532 RIOT timer and I/O ports for the Atari 2600 core (RAM excluded)
module riot_timer_io
   import riot_pkg::*;
#(
   parameter logic [7:0] TIMER_RESET = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   riot_timer_io_if.slave    bus,
   input  logic [7:0]        pa_in,
   output logic [7:0]        pa_out,
   output logic [7:0]        pa_oe,
   input  logic [7:0]        pb_in,
   output logic [7:0]        pb_out,
   output logic [7:0]        pb_oe
);

   logic [7:0] pa_out_q, pa_out_d, pa_oe_q, pa_oe_d;
   logic [7:0] pb_out_q, pb_out_d, pb_oe_q, pb_oe_d;
   logic       pa7_pos_q, pa7_pos_d, pa7_irq_en_q, pa7_irq_en_d;
   logic       pa7_flag_q, pa7_flag_d, pa7_in_q;
   logic       tim_irq_en_q, tim_irq_en_d;
   logic       rd, wr, wr_port, wr_edge, wr_timer, rd_intim, rd_timint, pa7_edge;
   logic [7:0] count;
   logic       timer_flag;

   assign rd        = bus.cs & ~bus.we;
   assign wr        = bus.cs & bus.we & bus.cpu_tick;
   assign wr_port   = wr & ~bus.addr[4] & ~bus.addr[2];
   assign wr_edge   = wr & ~bus.addr[4] &  bus.addr[2];
   assign wr_timer  = wr &  bus.addr[4];
   assign rd_intim  = rd & bus.cpu_tick & bus.addr[2] & ~bus.addr[0];
   assign rd_timint = rd & bus.cpu_tick & bus.addr[2] &  bus.addr[0];
   assign pa7_edge  = pa7_pos_q ? (pa_in[7] & ~pa7_in_q) : (~pa_in[7] & pa7_in_q);

   riot_interval_timer #(.TIMER_RESET(TIMER_RESET)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .tick     (bus.cpu_tick),
      .load     (wr_timer),
      .ld_val   (bus.wdata),
      .ld_sel   (interval_e'(bus.addr[1:0])),
      .clr_flag (rd_intim),
      .count    (count),
      .flag     (timer_flag)
   );

   always_comb begin
      pa_out_d     = pa_out_q;
      pa_oe_d      = pa_oe_q;
      pb_out_d     = pb_out_q;
      pb_oe_d      = pb_oe_q;
      pa7_pos_d    = pa7_pos_q;
      pa7_irq_en_d = pa7_irq_en_q;
      tim_irq_en_d = tim_irq_en_q;
      pa7_flag_d   = pa7_flag_q;
      if (wr_port) begin
         case (bus.addr[1:0])
            ADDR_SWCHA[1:0]:  pa_out_d = bus.wdata;
            ADDR_SWACNT[1:0]: pa_oe_d  = bus.wdata;
            ADDR_SWCHB[1:0]:  pb_out_d = bus.wdata;
            default:          pb_oe_d  = bus.wdata;
         endcase
      end
      // Edge-control settings come from the address lines, not the data bus
      if (wr_edge) {pa7_irq_en_d, pa7_pos_d} = bus.addr[1:0];
      if (wr_timer) tim_irq_en_d = bus.addr[3];
      if (rd_timint) pa7_flag_d = 1'b0;
      if (pa7_edge) pa7_flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pa_out_q     <= '0;
         pa_oe_q      <= '0;
         pb_out_q     <= '0;
         pb_oe_q      <= '0;
         pa7_pos_q    <= 1'b0;
         pa7_irq_en_q <= 1'b0;
         tim_irq_en_q <= 1'b0;
         pa7_flag_q   <= 1'b0;
         pa7_in_q     <= pa_in[7];
      end else begin
         pa_out_q     <= pa_out_d;
         pa_oe_q      <= pa_oe_d;
         pb_out_q     <= pb_out_d;
         pb_oe_q      <= pb_oe_d;
         pa7_pos_q    <= pa7_pos_d;
         pa7_irq_en_q <= pa7_irq_en_d;
         tim_irq_en_q <= tim_irq_en_d;
         pa7_flag_q   <= pa7_flag_d;
         pa7_in_q     <= pa_in[7];
      end
   end

   always_comb begin
      bus.rdata = 8'h00;
      if (rd) begin
         if (!bus.addr[2]) begin
            case (bus.addr[1:0])
               ADDR_SWCHA[1:0]:  bus.rdata = (pa_out_q & pa_oe_q) | (pa_in & ~pa_oe_q);
               ADDR_SWACNT[1:0]: bus.rdata = pa_oe_q;
               ADDR_SWCHB[1:0]:  bus.rdata = (pb_out_q & pb_oe_q) | (pb_in & ~pb_oe_q);
               default:          bus.rdata = pb_oe_q;
            endcase
         end else if (bus.addr[0]) begin
            bus.rdata = {timer_flag, pa7_flag_q, 6'b0};
         end else begin
            bus.rdata = count;
         end
      end
   end

   assign bus.irq = (timer_flag & tim_irq_en_q) | (pa7_flag_q & pa7_irq_en_q);
   assign pa_out  = pa_out_q;
   assign pa_oe   = pa_oe_q;
   assign pb_out  = pb_out_q;
   assign pb_oe   = pb_oe_q;

endmodule
